muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_if.sv | 20 ++
 rtl/muldiv_divstep.sv | 26 ++
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the default operand width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the datapath/controller (master) and the
// multiply/divide unit (slave).
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, srca, srcb, wr_hi, wr_lo, wdata,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, srca, srcb, wr_hi, wr_lo, wdata,
                    output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits and emit the quotient bit.
module muldiv_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Trial subtraction; the borrow out of the extra MSB says "does not fit".
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_divisor};
        o_qbit  = ~w_diff[WIDTH];
        if (o_qbit) begin
            o_rem = w_diff[WIDTH-1:0];
        end else begin
            o_rem = w_shift[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Defining MULDIV_FAST_MUL_EN
// replaces the shift-add multiply with a single-cycle combinational multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_e             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand, r_hi, r_lo;
    logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_done;

    logic               w_busy, w_load, w_step, w_fix;
    logic               w_op_div, w_sa, w_sb;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [2*WIDTH-1:0] w_load_acc, w_mul_next, w_div_next, w_prod_fix;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_ds_rem, w_quo_fix, w_rem_fix, w_res_hi, w_res_lo;
    logic               w_ds_q;

    // Operand signs and magnitudes for the request on the bus.
    always_comb begin
        w_op_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        if ((bus.op == OP_MULT) || (bus.op == OP_DIV)) begin
            w_sa = bus.srca[WIDTH-1];
            w_sb = bus.srcb[WIDTH-1];
        end else begin
            w_sa = 1'b0;
            w_sb = 1'b0;
        end
        w_mag_a = w_sa ? (~bus.srca + WIDTH'(1)) : bus.srca;
        w_mag_b = w_sb ? (~bus.srcb + WIDTH'(1)) : bus.srcb;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
    assign w_load_acc  = w_op_div ? {{WIDTH{1'b0}}, w_mag_a} : w_fast_prod;
`else
    assign w_load_acc  = {{WIDTH{1'b0}}, w_mag_a};
`endif

    // Multiply: acc = {partial product, multiplier}, add on LSB then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, quotient bits shift in at LSB.
    muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_divisor (r_mcand),
        .i_bit     (r_acc[WIDTH-1]),
        .o_rem     (w_ds_rem),
        .o_qbit    (w_ds_q)
    );
    assign w_div_next = {w_ds_rem, r_acc[WIDTH-2:0], w_ds_q};

    // Sign correction; a zero divisor leaves |srca| in the remainder, so
    // re-applying the dividend sign restores srca and only LO needs forcing.
    always_comb begin
        w_prod_fix = r_neg_q ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
        w_rem_fix  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : r_acc[2*WIDTH-1:WIDTH];
        if (r_dz) begin
            w_quo_fix = {WIDTH{1'b1}};
        end else begin
            w_quo_fix = r_neg_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
        end
        w_res_hi = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
        w_res_lo = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
`ifdef MULDIV_FAST_MUL_EN
                    w_next = w_op_div ? ST_RUN : ST_FIX;
`else
                    w_next = ST_RUN;
`endif
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_next = ST_FIX;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: busy and datapath enables.
    always_comb begin
        w_busy = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            ST_IDLE: w_load = bus.start;
            ST_RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
            end
            ST_FIX: begin
                w_busy = 1'b1;
                w_fix  = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    // Operand latch, iteration and HI/LO update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_done   <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_load) begin
                r_cnt    <= CW'(WIDTH-1);
                r_acc    <= w_load_acc;
                r_mcand  <= w_mag_b;
                r_is_div <= w_op_div;
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
                r_dz     <= w_op_div && (bus.srcb == {WIDTH{1'b0}});
            end
            if (w_step) begin
                r_cnt <= r_cnt - CW'(1);
                r_acc <= r_is_div ? w_div_next : w_mul_next;
            end
            if (w_fix) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (!w_busy) begin
                if (bus.wr_hi) r_hi <= bus.wdata;
                if (bus.wr_lo) r_lo <= bus.wdata;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {hi,lo,cycle},
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_hi", 64'(bus.hi), 64'(e.hi));
                chk("done_lo", 64'(bus.lo), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        sb.push_back('{hi: ehi, lo: elo, cyc: cyc + lat});
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.srca  = ~a;
                bus.srcb  = ~b;
            end
            chk({name, "_busy"}, 64'(bus.busy), (k < lat) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        chk({name, "_done_pulse_width"}, 64'(bus.done), 64'd0);
        chk({name, "_result_seen"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
        chk({name, "_result_seen"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        int c0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.srca  = '0;
        bus.srcb  = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);

        run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, DIV_LAT);
        run_op("div_min_by_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT);
        run_op("div_neg7by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LAT);

        // Second start while busy must be dropped.
        @(negedge clk);
        bus.start = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
        bus.op = OP_DIVU; bus.srca = 32'd100; bus.srcb = 32'd7;
        sb.push_back('{hi: 32'd2, lo: 32'd14, cyc: cyc + DIV_LAT});
`else
        bus.op = OP_MULTU; bus.srca = 32'd2; bus.srcb = 32'd3;
        sb.push_back('{hi: 32'd0, lo: 32'd6, cyc: cyc + MUL_LAT});
`endif
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 5) begin
                bus.start = 1'b1; bus.op = OP_DIVU; bus.srca = 32'd9; bus.srcb = 32'd3;
            end
            if (k == 6) bus.start = 1'b0;
        end
        repeat (40) @(negedge clk);
        chk("ignored_start_result_seen", 64'(sb.size()), 64'd0);
        sb.delete();

        // Reset in the middle of a divide: no done, registers cleared.
        @(negedge clk);
        c0 = cyc;
        bus.start = 1'b1; bus.op = OP_DIVU; bus.srca = 32'd100; bus.srcb = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_hi", 64'(bus.hi), 64'd0);
        chk("midreset_lo", 64'(bus.lo), 64'd0);
        chk("midreset_done", 64'(bus.done), 64'd0);
        repeat (40) @(negedge clk);
        run_op("divu_after_reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);

        // MTHI/MTLO in idle.
        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wdata = 32'h0000_1234;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        chk("mthi_hi", 64'(bus.hi), 64'h1234);
        chk("mthi_lo_kept", 64'(bus.lo), 64'd14);
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h0000_ABCD;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        chk("mthilo_hi", 64'(bus.hi), 64'hABCD);
        chk("mthilo_lo", 64'(bus.lo), 64'hABCD);
        bus.wr_lo = 1'b1; bus.wdata = 32'h0000_0055;
        @(negedge clk);
        bus.wr_lo = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'h55);
        chk("mtlo_hi_kept", 64'(bus.hi), 64'hABCD);

        // start + MTHI together, then writes while busy are dropped.
        bus.start = 1'b1; bus.op = OP_DIVU; bus.srca = 32'd100; bus.srcb = 32'd7;
        bus.wr_hi = 1'b1; bus.wdata = 32'h0000_BEEF;
        sb.push_back('{hi: 32'd2, lo: 32'd14, cyc: cyc + DIV_LAT});
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_with_mthi_hi", 64'(bus.hi), 64'hBEEF);
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h0000_5555;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        chk("busy_write_hi", 64'(bus.hi), 64'hBEEF);
        chk("busy_write_lo", 64'(bus.lo), 64'h55);
        wait_drain("start_with_mthi", 60);

        run_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
